// File: rtl/key_debounce_multi_pkg.sv
// key_debounce_multi_pkg
//   Shared definitions for the multi-channel key debouncer: the per-channel
//   FSM state encoding and the default timing constants for a 1 MHz clock.
//   This package has no ports.
package key_debounce_multi_pkg;

    // Per-channel debounce FSM states
    typedef enum logic {
        ST_STABLE = 1'b0,   // output agrees with the synchronised input
        ST_CHECK  = 1'b1    // input differs, counting out the stability window
    } deb_state_e;

    // Default timing constants at 1 MHz
    localparam int unsigned DEB_20MS_AT_1M = 20000;
    localparam int unsigned HOLD_1S_AT_1M  = 1000000;

endpackage : key_debounce_multi_pkg

// File: rtl/key_debounce_multi_channel.sv
// key_debounce_multi_channel
//   One debounced key: two-flop synchroniser, two-state stability FSM,
//   debounce counter, hold counter, and registered press/release/long strobes.
//
//   Ports
//     clk_i    in   system clock (1 MHz nominal)
//     rst_n_i  in   asynchronous active-low reset
//     s_i      in   raw asynchronous key input
//     s_o      out  debounced level
//     rise_o   out  one-cycle strobe on an accepted 0->1 transition
//     fall_o   out  one-cycle strobe on an accepted 1->0 transition
//     long_o   out  one-cycle strobe when s_o has been high HOLD_CYCLES
module key_debounce_multi_channel
    import key_debounce_multi_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEB_20MS_AT_1M,
    parameter int unsigned HOLD_CYCLES     = HOLD_1S_AT_1M,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic s_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o,
    output logic long_o
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES) + 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(HOLD_CYCLES - 2);

    logic              sync1;
    logic              sync2;
    deb_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hold_cnt;

    // Synchroniser stage: s_i -> sync1 -> sync2
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1 <= RESET_LEVEL;
            sync2 <= RESET_LEVEL;
        end else begin
            sync1 <= s_i;
            sync2 <= sync1;
        end
    end

    // Stability FSM stage: sync2 must differ from s_o for DEBOUNCE_CYCLES+1
    // consecutive edges; any edge where it agrees again aborts the check.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= ST_STABLE;
            cnt    <= '0;
            s_o    <= RESET_LEVEL;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            case (state)
                ST_STABLE: begin
                    cnt <= '0;
                    if (sync2 != s_o) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (sync2 == s_o) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        s_o    <= sync2;
                        rise_o <= sync2;
                        fall_o <= ~sync2;
                        state  <= ST_STABLE;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Hold stage: counts edges with s_o high and saturates at HOLD_LAST, so
    // long_o fires once per press on the edge the count reaches HOLD_LAST.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_cnt <= '0;
            long_o   <= 1'b0;
        end else if (!s_o) begin
            hold_cnt <= '0;
            long_o   <= 1'b0;
        end else begin
            long_o <= (hold_cnt == HOLD_PRE);
            if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

endmodule : key_debounce_multi_channel

// File: rtl/key_debounce_multi.sv
// key_debounce_multi
//   CH independent key debouncers for the 1 MHz board-input domain, placed
//   between raw button/switch pins and the control FSMs.
//
//   Ports
//     clk_i    in   system clock (1 MHz nominal)
//     rst_n_i  in   asynchronous active-low reset
//     s_i      in   [CH] raw asynchronous key/switch inputs
//     s_o      out  [CH] debounced levels
//     rise_o   out  [CH] one-cycle accepted 0->1 strobes
//     fall_o   out  [CH] one-cycle accepted 1->0 strobes
//     long_o   out  [CH] one-cycle strobes after HOLD_CYCLES held high
module key_debounce_multi
    import key_debounce_multi_pkg::*;
#(
    parameter int unsigned CH              = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEB_20MS_AT_1M,
    parameter int unsigned HOLD_CYCLES     = HOLD_1S_AT_1M,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [CH-1:0] s_i,
    output logic [CH-1:0] s_o,
    output logic [CH-1:0] rise_o,
    output logic [CH-1:0] fall_o,
    output logic [CH-1:0] long_o
);

    for (genvar g = 0; g < int'(CH); g++) begin : g_ch
        key_debounce_multi_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_ch (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .s_i     (s_i[g]),
            .s_o     (s_o[g]),
            .rise_o  (rise_o[g]),
            .fall_o  (fall_o[g]),
            .long_o  (long_o[g])
        );
    end

endmodule : key_debounce_multi
